// File: rtl/multicycle_add_sub_pkg.sv
// Shared types and helpers for the chunk-serial adder/subtractor.
//   state_t    : two-state sequencing FSM (IDLE, RUN)
//   idx_width(): width of the chunk index counter, never below one bit
package multicycle_add_sub_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // A single-chunk configuration still needs a one-bit index register.
   function automatic int idx_width(input int nchunk);
      return (nchunk > 1) ? $clog2(nchunk) : 1;
   endfunction

endpackage : multicycle_add_sub_pkg

// File: rtl/multicycle_add_sub_chunk_adder.sv
// Combinational CHUNK-bit adder slice used once per RUN cycle.
// Ports:
//   a, b   : CHUNK-bit addends
//   cin    : carry into bit 0
//   sum    : CHUNK-bit sum
//   cout   : carry out of the top bit
//   c_msb  : carry into the top bit (feeds signed-overflow detection)
module chunk_adder #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

   // The top sum bit is a ^ b ^ carry_in, so the carry into it falls out by
   // XORing the operands back off; this works for CHUNK = 1 as well.
   assign c_msb = sum[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule : chunk_adder

// File: rtl/multicycle_add_sub.sv
// Chunk-serial WIDTH-bit adder/subtractor, CHUNK bits per clock, with a
// registered carry between chunks and a start/busy/done handshake.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, accepted only in IDLE (including the done cycle)
//   Sub, C0    : 1 = subtract (C0 ignored), 0 = add with carry-in C0
//   A, B       : operands, captured with start
//   busy       : high while the chunks are being processed
//   done       : one-cycle pulse when Sum/Cout/Overflow are valid
//   Sum        : result, written chunk by chunk, LSB chunk first
//   Cout       : carry out of the MSB (subtract: 1 = no borrow)
//   Overflow   : two's-complement overflow
module multicycle_add_sub
   import multicycle_add_sub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             Sub,
   input  logic             C0,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Overflow
);

   localparam int               NCHUNK   = WIDTH / CHUNK;
   localparam int               IDX_W    = idx_width(NCHUNK);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry_q;
   logic [IDX_W-1:0] idx;

   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK-1:0] s_chunk;
   logic             c_chunk;
   logic             c_msb;

   // Select the current chunk with constant slices so every index is static.
   // NOTE: defaults first in always_comb so no path leaves a variable
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      a_chunk = '0;
      b_chunk = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (idx == IDX_W'(i)) begin
            a_chunk = a_q[i*CHUNK +: CHUNK];
            b_chunk = b_q[i*CHUNK +: CHUNK];
         end
      end
   end

   chunk_adder #(
      .CHUNK (CHUNK)
   ) u_chunk_adder (
      .a     (a_chunk),
      .b     (b_chunk),
      .cin   (carry_q),
      .sum   (s_chunk),
      .cout  (c_chunk),
      .c_msb (c_msb)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         idx      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         Sum      <= '0;
         Cout     <= 1'b0;
         Overflow <= 1'b0;
         carry_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_q     <= A;
                  // Subtraction is A + ~B + 1: invert B and force carry-in.
                  b_q     <= Sub ? ~B : B;
                  carry_q <= Sub | C0;
                  idx     <= '0;
                  busy    <= 1'b1;
                  state   <= ST_RUN;
               end
            end
            ST_RUN: begin
               for (int i = 0; i < NCHUNK; i++) begin
                  if (idx == IDX_W'(i)) begin
                     Sum[i*CHUNK +: CHUNK] <= s_chunk;
                  end
               end
               carry_q <= c_chunk;
               if (idx == LAST_IDX) begin
                  Cout     <= c_chunk;
                  Overflow <= c_msb ^ c_chunk;
                  idx      <= '0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= ST_IDLE;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule : multicycle_add_sub

// File: tb/tb_multicycle_add_sub.sv
// Directed and model-checked bench for multicycle_add_sub. Four instances
// (CHUNK = 8, 1, 4, 32 at WIDTH = 32) share the stimulus; each is checked
// for its own latency and for identical results.
module tb_multicycle_add_sub;

   localparam int W = 32;
   localparam int LAT [4] = '{4, 32, 8, 1};
   localparam int CHK [4] = '{8, 1, 4, 32};

   typedef struct {
      logic         sub;
      logic         c0;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         Sub = 1'b0;
   logic         C0 = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;

   logic [3:0]   busy_v;
   logic [3:0]   done_v;
   logic [W-1:0] sum_v [4];
   logic [3:0]   cout_v;
   logic [3:0]   ovf_v;

   int n_checks = 0;
   int n_fail   = 0;
   logic overlap = 1'b0;

   always #5 clk = ~clk;

   multicycle_add_sub #(.WIDTH(W), .CHUNK(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .Sub(Sub), .C0(C0), .A(A), .B(B),
      .busy(busy_v[0]), .done(done_v[0]), .Sum(sum_v[0]), .Cout(cout_v[0]), .Overflow(ovf_v[0]));
   multicycle_add_sub #(.WIDTH(W), .CHUNK(1)) u_c1 (
      .clk(clk), .rst_n(rst_n), .start(start), .Sub(Sub), .C0(C0), .A(A), .B(B),
      .busy(busy_v[1]), .done(done_v[1]), .Sum(sum_v[1]), .Cout(cout_v[1]), .Overflow(ovf_v[1]));
   multicycle_add_sub #(.WIDTH(W), .CHUNK(4)) u_c4 (
      .clk(clk), .rst_n(rst_n), .start(start), .Sub(Sub), .C0(C0), .A(A), .B(B),
      .busy(busy_v[2]), .done(done_v[2]), .Sum(sum_v[2]), .Cout(cout_v[2]), .Overflow(ovf_v[2]));
   multicycle_add_sub #(.WIDTH(W), .CHUNK(32)) u_c32 (
      .clk(clk), .rst_n(rst_n), .start(start), .Sub(Sub), .C0(C0), .A(A), .B(B),
      .busy(busy_v[3]), .done(done_v[3]), .Sum(sum_v[3]), .Cout(cout_v[3]), .Overflow(ovf_v[3]));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Independent full-width reference: A + (Sub ? ~B : B) + (Sub ? 1 : C0).
   function automatic vec_t model(input logic sub, input logic c0,
                                  input logic [W-1:0] a, input logic [W-1:0] b);
      vec_t         v;
      logic [W-1:0] bb;
      logic [W:0]   full;
      bb     = sub ? ~b : b;
      full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub | c0)};
      v.sub  = sub;
      v.c0   = c0;
      v.a    = a;
      v.b    = b;
      v.sum  = full[W-1:0];
      v.cout = full[W];
      v.ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
      return v;
   endfunction

   // Launch one op on all instances, scramble the inputs during RUN, and
   // check each instance's latency and result against v.
   task automatic run_vec(input vec_t v, input string tag);
      bit           seen [4];
      int           lat  [4];
      logic [W-1:0] s    [4];
      logic         co   [4];
      logic         ov   [4];
      int           nseen;
      nseen = 0;
      for (int d = 0; d < 4; d++) begin
         seen[d] = 1'b0; lat[d] = 0; s[d] = '0; co[d] = 1'b0; ov[d] = 1'b0;
      end
      @(negedge clk);
      A = v.a; B = v.b; Sub = v.sub; C0 = v.c0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      A = $urandom; B = $urandom; Sub = ~v.sub; C0 = ~v.c0;
      for (int d = 0; d < 4; d++)
         check($sformatf("%s_c%0d_busy", tag, CHK[d]), 64'(busy_v[d]), 64'd1);
      for (int cyc = 1; cyc <= 40 && nseen < 4; cyc++) begin
         @(posedge clk);
         #1;
         for (int d = 0; d < 4; d++) begin
            if (busy_v[d] && done_v[d]) overlap = 1'b1;
            if (done_v[d] && !seen[d]) begin
               seen[d] = 1'b1; lat[d] = cyc; s[d] = sum_v[d];
               co[d] = cout_v[d]; ov[d] = ovf_v[d]; nseen++;
            end
         end
      end
      for (int d = 0; d < 4; d++) begin
         if (!seen[d]) begin
            check($sformatf("%s_c%0d_done_timeout", tag, CHK[d]), 64'd0, 64'd1);
         end else begin
            check($sformatf("%s_c%0d_latency", tag, CHK[d]), 64'(lat[d]), 64'(LAT[d]));
            check($sformatf("%s_c%0d_sum", tag, CHK[d]), 64'(s[d]), 64'(v.sum));
            check($sformatf("%s_c%0d_cout", tag, CHK[d]), 64'(co[d]), 64'(v.cout));
            check($sformatf("%s_c%0d_ovf", tag, CHK[d]), 64'(ov[d]), 64'(v.ovf));
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [11];
      vec_t rv;
      int   cyc;
      logic flag;

      //         sub   c0    a             b             sum           cout  ovf
      vecs[0]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
      vecs[2]  = '{1'b0, 1'b1, 32'h00000010, 32'h00000020, 32'h00000031, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1};
      vecs[5]  = '{1'b1, 1'b1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1};
      vecs[8]  = '{1'b0, 1'b0, 32'h12345678, 32'h0F0F0F0F, 32'h21436587, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 32'h000000FF, 32'h00000000, 32'h00000100, 1'b0, 1'b0};

      // Reset state.
      #2;
      for (int d = 0; d < 4; d++)
         check($sformatf("reset_c%0d", CHK[d]),
               64'({busy_v[d], done_v[d], sum_v[d], cout_v[d], ovf_v[d]}), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed table.
      for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // start pulsed during RUN with other operands must be ignored.
      repeat (40) @(posedge clk);
      @(negedge clk);
      A = 32'h7FFFFFFF; B = 32'h1; Sub = 1'b0; C0 = 1'b0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      A = 32'h11111111; B = 32'h22222222; Sub = 1'b1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      cyc = 3;
      while (cyc < 20 && !done_v[0]) begin
         @(posedge clk); #1;
         if (!done_v[0]) cyc++;
      end
      check("midrun_start_latency", 64'(cyc), 64'd4);
      check("midrun_start_sum", 64'(sum_v[0]), 64'h80000000);
      check("midrun_start_flags", 64'({cout_v[0], ovf_v[0]}), 64'b01);

      // Back-to-back: start held in the done cycle launches with no gap.
      repeat (40) @(posedge clk);
      @(negedge clk);
      A = 32'hFFFFFFFF; B = 32'h1; Sub = 1'b0; C0 = 1'b0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("b2b_first_early", 64'(done_v[0]), 64'd0);
      @(posedge clk); #1;
      check("b2b_first_done", 64'(done_v[0]), 64'd1);
      check("b2b_first_sum", 64'({cout_v[0], sum_v[0]}), 64'h1_00000000);
      A = 32'h12345678; B = 32'h0F0F0F0F; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      check("b2b_second_busy", 64'({busy_v[0], done_v[0]}), 64'b10);
      repeat (3) @(posedge clk);
      #1;
      check("b2b_second_early", 64'(done_v[0]), 64'd0);
      @(posedge clk); #1;
      check("b2b_second_done", 64'(done_v[0]), 64'd1);
      check("b2b_second_sum", 64'({cout_v[0], sum_v[0]}), 64'h0_21436587);

      // Reset during the second RUN cycle aborts without a done.
      repeat (40) @(posedge clk);
      @(negedge clk);
      A = 32'h7FFFFFFF; B = 32'h1; Sub = 1'b0; C0 = 1'b0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("abort_outputs",
            64'({busy_v[0], done_v[0], sum_v[0], cout_v[0], ovf_v[0]}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      flag = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done_v[0] || busy_v[0]) flag = 1'b1;
      end
      check("abort_no_done", 64'(flag), 64'd0);
      run_vec(vecs[4], "after_abort");

      // Model-checked sweep across all chunk sizes.
      for (int i = 0; i < 16; i++) begin
         rv = model(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom, $urandom);
         run_vec(rv, $sformatf("rnd%0d", i));
      end

      check("busy_done_exclusive", 64'(overlap), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_multicycle_add_sub
